hs_frame_sequencer: RTL and testbench

//  Raster/frame controller for the hsOptFlowTop streaming datapath. It tracks the input

---
 rtl/hs_frame_sequencer_if.sv | 33 +++
 rtl/hs_frame_sequencer.sv | 118 +++++++++++
 tb/tb_hs_frame_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hs_frame_sequencer_if.sv
// rtl/hs_frame_sequencer_if.sv - frame sync input and raster/position/output-window signals
interface hs_frame_sequencer_if #(
  parameter int XW = 10,
  parameter int YW = 8
);
  logic          io_frame_sync_in;
  logic          io_pix_valid;
  logic [XW-1:0] io_x;
  logic [YW-1:0] io_y;
  logic          io_first_col;
  logic          io_last_col;
  logic          io_first_row;
  logic          io_last_row;
  logic          io_frame_sync_out;
  logic          io_out_valid;
  logic          io_busy;
  logic          io_sync_err;
  logic [15:0]   io_frame_count;

  modport master (
    input  io_frame_sync_in,
    output io_pix_valid, io_x, io_y, io_first_col, io_last_col, io_first_row,
           io_last_row, io_frame_sync_out, io_out_valid, io_busy, io_sync_err,
           io_frame_count
  );

  modport slave (
    output io_frame_sync_in,
    input  io_pix_valid, io_x, io_y, io_first_col, io_last_col, io_first_row,
           io_last_row, io_frame_sync_out, io_out_valid, io_busy, io_sync_err,
           io_frame_count
  );
endinterface

// File: rtl/hs_frame_sequencer.sv
// rtl/hs_frame_sequencer.sv - raster position tracker with latency-aligned frame sync and output window
module hs_frame_sequencer #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 256,
  parameter int PIPE_LAT = 1034,
  parameter int XW       = 10,
  parameter int YW       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  hs_frame_sequencer_if.master  bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int LW   = $clog2(PIPE_LAT + 1);
  localparam int OW   = $clog2(NPIX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [XW-1:0] w_x;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] r_y;
  logic [YW-1:0] w_y;
  logic [YW-1:0] w_y_nxt;
  logic          w_start;
  logic          w_pix_valid;
  logic          w_last_x;
  logic          w_last_y;
  logic          w_sync_out;
  logic          r_lat_active;
  logic [LW-1:0] r_lat_cnt;
  logic [OW-1:0] r_out_cnt;
  logic [15:0]   r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // A sync always wins: the pixel presented with it is (0,0), whatever the registers hold.
  always_comb begin
    w_start     = bus.io_frame_sync_in & ~reset;
    w_pix_valid = w_start | (r_state == RUN);
    w_x         = w_start ? '0 : r_x;
    w_y         = w_start ? '0 : r_y;
    w_last_x    = (w_x == XW'(IMG_W - 1));
    w_last_y    = (w_y == YW'(IMG_H - 1));
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    if (w_pix_valid) begin
      w_state_nxt = RUN;
      if (w_last_x) begin
        w_x_nxt = '0;
        if (w_last_y) begin
          w_y_nxt     = '0;
          w_state_nxt = IDLE;
        end else begin
          w_y_nxt = w_y + YW'(1);
        end
      end else begin
        w_x_nxt = w_x + XW'(1);
        w_y_nxt = w_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_active  <= 1'b0;
      r_lat_cnt     <= '0;
      r_out_cnt     <= '0;
      r_frame_count <= '0;
    end else begin
      // Reloading on every start also discards the pending sync of an aborted frame.
      if (w_start) begin
        r_lat_active  <= 1'b1;
        r_lat_cnt     <= LW'(PIPE_LAT - 1);
        r_frame_count <= r_frame_count + 16'd1;
      end else if (r_lat_active) begin
        if (r_lat_cnt == '0) begin
          r_lat_active <= 1'b0;
        end else begin
          r_lat_cnt <= r_lat_cnt - LW'(1);
        end
      end
      if (w_sync_out) begin
        r_out_cnt <= OW'(NPIX - 1);
      end else if (r_out_cnt != '0) begin
        r_out_cnt <= r_out_cnt - OW'(1);
      end
    end
  end

  assign w_sync_out = r_lat_active & (r_lat_cnt == '0);

  assign bus.io_pix_valid      = w_pix_valid;
  assign bus.io_x              = w_x;
  assign bus.io_y              = w_y;
  assign bus.io_first_col      = w_pix_valid & (w_x == '0);
  assign bus.io_last_col       = w_pix_valid & w_last_x;
  assign bus.io_first_row      = w_pix_valid & (w_y == '0);
  assign bus.io_last_row       = w_pix_valid & w_last_y;
  assign bus.io_frame_sync_out = w_sync_out;
  assign bus.io_out_valid      = w_sync_out | (r_out_cnt != '0);
  assign bus.io_busy           = (r_state != IDLE) | r_lat_active | (r_out_cnt != '0);
  assign bus.io_sync_err       = w_start & (r_state == RUN);
  assign bus.io_frame_count    = r_frame_count;
endmodule

// File: tb/tb_hs_frame_sequencer.sv
// tb/tb_hs_frame_sequencer.sv - directed vector bench for hs_frame_sequencer (8x4 image, latency 5)
module tb_hs_frame_sequencer;
  localparam int NSC  = 5;
  localparam int NCHK = 35;
  localparam int D    = -1;

  typedef struct {
    int s0;
    int s1;
    int rst;
    int ncyc;
  } sc_t;

  typedef struct {
    int sc;
    int cyc;
    int pv;
    int x;
    int y;
    int fcol;
    int lcol;
    int frow;
    int lrow;
    int so;
    int ov;
    int busy;
    int err;
    int fc;
  } chk_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  sc_t  scs  [0:NSC-1];
  chk_t chks [0:NCHK-1];

  hs_frame_sequencer_if #(.XW(3), .YW(2)) bus ();

  hs_frame_sequencer #(
    .IMG_W(8), .IMG_H(4), .PIPE_LAT(5), .XW(3), .YW(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int sc, input int cyc, input int act, input int exp);
    if (exp < 0) return;
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s sc=%0d cyc=%0d got=%0d want=%0d", nm, sc, cyc, act, exp);
    end
  endtask

  task automatic check_vec(input int k);
    chk("pix_valid", chks[k].sc, chks[k].cyc, int'(bus.io_pix_valid), chks[k].pv);
    chk("x", chks[k].sc, chks[k].cyc, int'(bus.io_x), chks[k].x);
    chk("y", chks[k].sc, chks[k].cyc, int'(bus.io_y), chks[k].y);
    chk("first_col", chks[k].sc, chks[k].cyc, int'(bus.io_first_col), chks[k].fcol);
    chk("last_col", chks[k].sc, chks[k].cyc, int'(bus.io_last_col), chks[k].lcol);
    chk("first_row", chks[k].sc, chks[k].cyc, int'(bus.io_first_row), chks[k].frow);
    chk("last_row", chks[k].sc, chks[k].cyc, int'(bus.io_last_row), chks[k].lrow);
    chk("sync_out", chks[k].sc, chks[k].cyc, int'(bus.io_frame_sync_out), chks[k].so);
    chk("out_valid", chks[k].sc, chks[k].cyc, int'(bus.io_out_valid), chks[k].ov);
    chk("busy", chks[k].sc, chks[k].cyc, int'(bus.io_busy), chks[k].busy);
    chk("sync_err", chks[k].sc, chks[k].cyc, int'(bus.io_sync_err), chks[k].err);
    chk("frame_count", chks[k].sc, chks[k].cyc, int'(bus.io_frame_count), chks[k].fc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.io_frame_sync_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.io_frame_sync_in = 1'b0;

    // stimulus: sync cycles s0/s1, reset cycle, last cycle (-1 = unused)
    scs = '{
      '{10, -1, -1, 50},
      '{10, 42, -1, 82},
      '{10, 13, -1, 52},
      '{10, -1, 12, 30},
      '{10, 41, -1, 80}
    };

    //    sc cyc pv x  y fc lc fr lr so ov bsy err fcnt
    chks = '{
      '{0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 10, 1, 0, 0, 1, 0, 1, 0, 0, 0, D, 0, D},
      '{0, 14, 1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1},
      '{0, 15, 1, 5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1},
      '{0, 17, 1, 7, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1},
      '{0, 18, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1},
      '{0, 34, 1, 0, 3, 1, 0, 0, 1, 0, 1, 1, 0, 1},
      '{0, 41, 1, 7, 3, 0, 1, 0, 1, 0, 1, 1, 0, 1},
      '{0, 42, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1},
      '{0, 46, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1},
      '{0, 47, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1},
      '{1, 41, 1, 7, 3, 0, 1, 0, 1, 0, 1, 1, 0, 1},
      '{1, 42, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1},
      '{1, 47, 1, 5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 2},
      '{1, 73, 1, 7, 3, 0, 1, 0, 1, 0, 1, 1, 0, 2},
      '{1, 74, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2},
      '{1, 78, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2},
      '{1, 79, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2},
      '{2, 12, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1},
      '{2, 13, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1},
      '{2, 14, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2},
      '{2, 15, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2},
      '{2, 18, 1, 5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 2},
      '{2, 49, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2},
      '{2, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2},
      '{3, 11, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1},
      '{3, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{3, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{4, 40, 1, 6, 3, 0, 0, 0, 1, 0, 1, 1, 0, 1},
      '{4, 41, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1},
      '{4, 42, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 2},
      '{4, 46, 1, 5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 2},
      '{4, 77, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2},
      '{4, 78, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2}
    };

    for (int si = 0; si < NSC; si++) begin
      do_reset();
      for (int c = 0; c <= scs[si].ncyc; c++) begin
        bus.io_frame_sync_in = (c == scs[si].s0) || (c == scs[si].s1);
        reset = (c == scs[si].rst);
        #4;
        for (int k = 0; k < NCHK; k++) begin
          if (chks[k].sc == si && chks[k].cyc == c) check_vec(k);
        end
        @(posedge clk);
        #1;
      end
    end

    // frame counter wrap: a sync every cycle; each one after the first is a resync
    do_reset();
    for (int c = 0; c < 65540; c++) begin
      bus.io_frame_sync_in = 1'b1;
      #4;
      if (c == 0) chk("wrap_err_first", 5, c, int'(bus.io_sync_err), 0);
      if (c == 1) chk("wrap_err_resync", 5, c, int'(bus.io_sync_err), 1);
      if (c == 65535) chk("wrap_fc_max", 5, c, int'(bus.io_frame_count), 65535);
      if (c == 65536) chk("wrap_fc_zero", 5, c, int'(bus.io_frame_count), 0);
      @(posedge clk);
      #1;
    end
    bus.io_frame_sync_in = 1'b0;
    #4;
    chk("wrap_fc_final", 5, 65540, int'(bus.io_frame_count), 4);
    chk("wrap_x_after", 5, 65540, int'(bus.io_x), 1);
    chk("wrap_err_after", 5, 65540, int'(bus.io_sync_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
